lsu: RTL and testbench
======================

# lsu

Load/store unit of the rysyCore execute/memory boundary. It takes the effective address produced by the ALU, plus the store data and the load/store width from decode. It then runs one data-memory transaction over a req/ack bus and returns sign- or zero-extended load data to writeback. Misaligned accesses, illegal width codes and bus timeouts are reported as single-cycle exception pulses.

## Interface
- REG_LEN, 32 (from rysyPkg), data/address width; not overridable.
- MEM_TIMEOUT, 255, maximum number of BUSY cycles without mem_ack before a bus error; range 1..255.

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- req_addr  in  REG_LEN  effective address (ALU result)
- req_wdata  in  REG_LEN  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  bus write enable
- mem_addr  out  REG_LEN  word address, {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  REG_LEN  lane-replicated store data
- mem_ack  in  1  bus completion; mem_rdata valid in same cycle
- mem_rdata  in  REG_LEN  read word
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  destination register
- wb_data  out  REG_LEN  extended load data
- exc_misaligned  out  1  one-cycle pulse: misaligned or illegal funct3
- exc_bus_err  out  1  one-cycle pulse: timeout
- exc_addr  out  REG_LEN  faulting req_addr, held until next exception

## Operation
- States: IDLE, BUSY.
- In IDLE, a handshake (req_valid && req_ready) latches we, funct3, addr, wdata and rd.
- The request is checked at acceptance:
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0
  - illegal: load funct3 ∈ {011,110,111}; store funct3 ≥ 011
  - Either case: no bus access, state stays IDLE, exc_misaligned=1 and exc_addr=req_addr next cycle.
- A good request goes IDLE→BUSY, with mem_req/mem_we/mem_addr/mem_be/mem_wdata registered.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}}
  - SW: be = 4'b1111, wdata unchanged
- Loads: mem_be is 4'b1111. The selected byte/half is rdata>>(8*addr[1:0]), sign-extended for LB/LH and zero-extended for LBU/LHU.
- BUSY with mem_ack=1: mem_req drops next cycle and the state returns to IDLE.
  - Load: wb_valid=1 with wb_rd and wb_data for exactly one cycle.
  - Store: no wb_valid.
- BUSY without ack: an 8-bit counter (cleared on entry) increments each cycle. When the count reaches MEM_TIMEOUT−1 with no ack:
  - mem_req drops and the state returns to IDLE
  - exc_bus_err pulses, exc_addr = latched address
- Ack and timeout in the same cycle: ack wins and the op completes normally.
- mem_ack in IDLE is ignored (stale ack after reset or timeout).
- rd = 0 loads still access memory and pulse wb_valid; the register file discards the result.
- Bus outputs hold their values for the whole of BUSY.

## Timing
- Reset (asynchronous on rst_n low): state IDLE, counter 0, and every output 0 except req_ready=1. A transaction in flight is abandoned immediately, with no wb or exception.
- Request accepted at cycle N:
  - mem_req high from N+1.
  - mem_ack at cycle M ≥ N+1 gives wb_valid at M+1 and req_ready high at M+1.
  - Minimum load latency is 2 cycles; new requests can be accepted every 2 cycles.
- Misaligned request at N: exc_misaligned at N+1, and req_ready stays high, so back-to-back requests are allowed.
- Timeout: mem_req is high for exactly MEM_TIMEOUT cycles, then low. exc_bus_err coincides with the first cycle mem_req is low.
- Outputs are registered; there is no combinational path from any bus input to any bus output. req_ready depends only on state.

## Test plan
- Reset then LW addr=0x100 with ack 2 cycles after mem_req, rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, wb_valid one cycle with wb_data=0xDEADBEEF and wb_rd echoed.
- LB addr=0x103 with rdata=0x80FF_FF7F -> wb_data=0xFFFFFF80. The same access as LBU -> 0x00000080. LH addr=0x102 -> 0xFFFF80FF.
- SB addr=0x201 wdata=0x12345678 -> mem_addr=0x200, be=0010, mem_wdata=0x78787878, no wb_valid. SH addr=0x202 -> be=1100, wdata=0x56785678.
- LW addr=0x102, then SH addr=0x001, then load funct3=011 on consecutive cycles -> three exc_misaligned pulses with matching exc_addr, mem_req never asserts.
- MEM_TIMEOUT=4 with no ack -> mem_req high 4 cycles, then exc_bus_err. A repeat with ack on the 4th cycle -> normal wb and no bus error. A late ack in IDLE is ignored.
- rst_n asserted mid-BUSY -> mem_req low immediately. After release, ack is ignored, req_ready=1, and the next LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from execute, runs it over a req/ack bus,
// and returns extended load data or a single-cycle exception pulse.
module lsu #(
    parameter  int MEM_TIMEOUT = 255,
    localparam int REG_LEN     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [REG_LEN-1:0] req_addr,
    input  logic [REG_LEN-1:0] req_wdata,
    input  logic [4:0]         req_rd,
    output logic               mem_req,
    output logic               mem_we,
    output logic [REG_LEN-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [REG_LEN-1:0] mem_wdata,
    input  logic               mem_ack,
    input  logic [REG_LEN-1:0] mem_rdata,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [REG_LEN-1:0] wb_data,
    output logic               exc_misaligned,
    output logic               exc_bus_err,
    output logic [REG_LEN-1:0] exc_addr
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t               state, state_next;
    logic [7:0]           cnt;
    logic                 lat_we;
    logic [2:0]           lat_funct3;
    logic [REG_LEN-1:0]   lat_addr;
    logic [4:0]           lat_rd;

    logic                 accept, misaligned, illegal, bad_req;
    logic                 done_ack, timeout;
    logic [3:0]           be_calc;
    logic [REG_LEN-1:0]   wdata_calc, load_shift, load_ext;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign bad_req   = misaligned || illegal;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (req_we)
            illegal = (req_funct3 >= 3'b011);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

    // Stores replicate the datum across lanes; the byte enables pick the target.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = '0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_calc    = 4'b0001 << req_addr[1:0];
                    wdata_calc = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_calc    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_calc = {2{req_wdata[15:0]}};
                end
                default: wdata_calc = req_wdata;
            endcase
        end
    end

    assign load_shift = mem_rdata >> {lat_addr[1:0], 3'b000};

    always_comb begin
        case (lat_funct3)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {24'b0, load_shift[7:0]};
            3'b101:  load_ext = {16'b0, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    // Ack is tested before the counter so a same-cycle ack beats the timeout.
    always_comb begin
        state_next = state;
        done_ack   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: if (accept && !bad_req) state_next = BUSY;
            BUSY: begin
                if (mem_ack) begin
                    done_ack   = 1'b1;
                    state_next = IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            lat_we         <= 1'b0;
            lat_funct3     <= '0;
            lat_addr       <= '0;
            lat_rd         <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            exc_misaligned <= 1'b0;
            exc_bus_err    <= 1'b0;
            exc_addr       <= '0;
        end else begin
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_err    <= 1'b0;

            if (accept) begin
                if (bad_req) begin
                    exc_misaligned <= 1'b1;
                    exc_addr       <= req_addr;
                end else begin
                    lat_we     <= req_we;
                    lat_funct3 <= req_funct3;
                    lat_addr   <= req_addr;
                    lat_rd     <= req_rd;
                    cnt        <= '0;
                    mem_req    <= 1'b1;
                    mem_we     <= req_we;
                    mem_addr   <= {req_addr[REG_LEN-1:2], 2'b00};
                    mem_be     <= be_calc;
                    mem_wdata  <= wdata_calc;
                end
            end

            if (done_ack) begin
                mem_req <= 1'b0;
                if (!lat_we) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= lat_rd;
                    wb_data  <= load_ext;
                end
            end else if (timeout) begin
                mem_req     <= 1'b0;
                exc_bus_err <= 1'b1;
                exc_addr    <= lat_addr;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written corner
// sequences, and randomized ops scored against an arithmetic reference model.
module tb_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misaligned, exc_bus_err;
    logic [31:0] exc_addr;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misaligned(exc_misaligned), .exc_bus_err(exc_bus_err),
        .exc_addr(exc_addr)
    );

    typedef struct {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          ack_delay;
        logic        exp_exc;
        logic        exp_tmo;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [4:0] rd, input int dly, input logic [31:0] maddr,
                                input logic [3:0] be, input logic [31:0] ewdata,
                                input logic [31:0] edata);
        vec_t v;
        v.we = we; v.funct3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rd = rd; v.ack_delay = dly; v.exp_exc = 1'b0; v.exp_tmo = 1'b0;
        v.exp_maddr = maddr; v.exp_be = be; v.exp_wdata = ewdata; v.exp_data = edata;
        return v;
    endfunction

    // Reference model: access size, legality and extension from plain arithmetic.
    function automatic vec_t model(input vec_t v);
        int unsigned      off, size;
        logic             legal;
        longint unsigned  val, span;
        off  = v.addr % 4;
        case (v.funct3 % 4)
            0:       size = 1;
            1:       size = 2;
            default: size = 4;
        endcase
        legal = v.we ? (v.funct3 <= 3'd2)
                     : (v.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        v.exp_exc   = !legal || (off % size != 0);
        v.exp_tmo   = !v.exp_exc && (v.ack_delay >= TMO);
        v.exp_maddr = v.addr - off;
        v.exp_be    = v.we ? 4'(((1 << size) - 1) << off) : 4'hF;
        case (size)
            1:       v.exp_wdata = 32'((v.wdata % 256) * 32'h0101_0101);
            2:       v.exp_wdata = 32'((v.wdata % 65536) * 32'h0001_0001);
            default: v.exp_wdata = v.wdata;
        endcase
        span = longint'(1) << (8 * size);
        val  = (longint'(v.rdata) >> (8 * off)) % span;
        if (v.funct3 < 3'd4 && size < 4 && val >= span / 2)
            val = val + (longint'(1) << 32) - span;
        v.exp_data = 32'(val);
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int cyc;
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.funct3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        tick();
        req_valid = 1'b0;
        if (v.exp_exc) begin
            check("exc_misaligned", 32'(exc_misaligned), 32'd1);
            check("exc_addr_mis", exc_addr, v.addr);
            check("mem_req_on_exc", 32'(mem_req), 32'd0);
            tick();
            check("exc_mis_pulse_end", 32'(exc_misaligned), 32'd0);
        end else begin
            check("mem_req_start", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(v.we));
            check("mem_addr", mem_addr, v.exp_maddr);
            check("mem_be", 32'(mem_be), 32'(v.exp_be));
            if (v.we) check("mem_wdata", mem_wdata, v.exp_wdata);
            if (v.exp_tmo) begin
                cyc = 1;
                while (mem_req && cyc < 50) begin
                    tick();
                    if (mem_req) cyc++;
                end
                check("tmo_req_cycles", 32'(cyc), 32'(TMO));
                check("exc_bus_err", 32'(exc_bus_err), 32'd1);
                check("exc_addr_tmo", exc_addr, v.addr);
                check("wb_on_tmo", 32'(wb_valid), 32'd0);
                tick();
                check("bus_err_pulse_end", 32'(exc_bus_err), 32'd0);
            end else begin
                repeat (v.ack_delay) tick();
                check("mem_req_held", 32'(mem_req), 32'd1);
                check("mem_addr_held", mem_addr, v.exp_maddr);
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
                tick();
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                check("mem_req_drop", 32'(mem_req), 32'd0);
                check("req_ready_after", 32'(req_ready), 32'd1);
                check("wb_valid", 32'(wb_valid), 32'(!v.we));
                check("no_bus_err", 32'(exc_bus_err), 32'd0);
                if (!v.we) begin
                    check("wb_data", wb_data, v.exp_data);
                    check("wb_rd", 32'(wb_rd), 32'(v.rd));
                end
                tick();
                check("wb_pulse_end", 32'(wb_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        vec_t bad[3];

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;

        //          we  f3    addr          wdata         rdata         rd  dly maddr         be       ewdata        edata
        tbl[0] = mk(0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5, 2, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        tbl[1] = mk(0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 7, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80);
        tbl[2] = mk(0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 8, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080);
        tbl[3] = mk(0, 3'd1, 32'h0000_0102, 32'h0,        32'h80FF_FF7F, 9, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_80FF);
        tbl[4] = mk(1, 3'd0, 32'h0000_0201, 32'h1234_5678, 32'h0,        0, 1, 32'h0000_0200, 4'b0010, 32'h7878_7878, 32'h0);
        tbl[5] = mk(1, 3'd1, 32'h0000_0202, 32'h1234_5678, 32'h0,        0, 0, 32'h0000_0200, 4'b1100, 32'h5678_5678, 32'h0);
        tbl[6] = mk(0, 3'd5, 32'h0000_0000, 32'h0,        32'h1234_8001, 3, 0, 32'h0000_0000, 4'b1111, 32'h0,        32'h0000_8001);
        tbl[7] = mk(0, 3'd2, 32'h0000_010C, 32'h0,        32'hCAFE_F00D, 4, 3, 32'h0000_010C, 4'b1111, 32'h0,        32'hCAFE_F00D);
        tbl[8] = mk(0, 3'd2, 32'h0000_0300, 32'h0,        32'h0BAD_CAFE, 0, 0, 32'h0000_0300, 4'b1111, 32'h0,        32'h0BAD_CAFE);

        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_op(tbl[i]);

        // Three bad requests on consecutive cycles: LW misaligned, SH misaligned, load f3=011.
        bad[0] = mk(0, 3'd2, 32'h0000_0102, 32'h0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        bad[1] = mk(1, 3'd1, 32'h0000_0001, 32'h0, 32'h0, 2, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        bad[2] = mk(0, 3'd3, 32'h0000_0040, 32'h0, 32'h0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("b2b_ready", 32'(req_ready), 32'd1);
            req_valid = 1'b1; req_we = bad[i].we; req_funct3 = bad[i].funct3;
            req_addr = bad[i].addr; req_rd = bad[i].rd;
            tick();
            check("b2b_exc", 32'(exc_misaligned), 32'd1);
            check("b2b_exc_addr", exc_addr, bad[i].addr);
            check("b2b_no_mem_req", 32'(mem_req), 32'd0);
        end
        req_valid = 1'b0;
        tick();
        check("b2b_exc_end", 32'(exc_misaligned), 32'd0);

        // Timeout, then a late ack arriving in IDLE.
        v = mk(0, 3'd2, 32'h0000_0480, 32'h0, 32'h1111_2222, 6, 10, 32'h0, 4'h0, 32'h0, 32'h0);
        v = model(v);
        run_op(v);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        check("late_ack_no_wb", 32'(wb_valid), 32'd0);
        check("late_ack_no_req", 32'(mem_req), 32'd0);
        check("late_ack_ready", 32'(req_ready), 32'd1);

        // Reset asserted mid-BUSY abandons the transaction at once.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0500; req_rd = 5'd11;
        tick();
        req_valid = 1'b0;
        check("pre_rst_busy", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("post_rst_ack_no_wb", 32'(wb_valid), 32'd0);
        check("post_rst_ack_no_err", 32'(exc_bus_err), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        run_op(tbl[0]);

        for (int i = 0; i < 80; i++) begin
            v.we        = 1'($urandom_range(0, 1));
            v.funct3    = 3'($urandom_range(0, 7));
            v.addr      = 32'h0000_0400 + 32'($urandom_range(0, 63));
            v.wdata     = $urandom;
            v.rdata     = $urandom;
            v.rd        = 5'($urandom_range(0, 31));
            v.ack_delay = int'($urandom_range(0, 5));
            v = model(v);
            run_op(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
